// File: rtl/snncore_prog_rx_pkg.sv
// Shared types and constants for the snncore programming-port responder.
package snn_prog_pkg;

  localparam int unsigned CFG_VTH               = 0;
  localparam int unsigned CFG_DECAY_RATE        = 1;
  localparam int unsigned CFG_GROW_RATE         = 2;
  localparam int unsigned CFG_VREST             = 3;
  localparam int unsigned CFG_RESET_MECHANISM   = 4;
  localparam int unsigned CFG_REFRACTORY_PERIOD = 5;
  localparam int unsigned CFG_LAYER_TO_MONITOR  = 6;
  localparam int unsigned CFG_NEURON_TO_MONITOR = 7;
  localparam int unsigned CFG_REGS              = 8;

  localparam int unsigned LAYER_MSB = 31;
  localparam int unsigned LAYER_LSB = 24;
  // The layer field sits directly above the synapse address, capping its width.
  localparam int unsigned SYN_ADDR_W_MAX = LAYER_LSB;

  typedef enum logic {
    LOAD,
    READY
  } prog_state_t;

  typedef struct packed {
    logic [7:0]                layer;
    logic [SYN_ADDR_W_MAX-1:0] addr;
    logic [31:0]               data;
  } syn_wr_t;

endpackage

// File: rtl/snncore_prog_rx_if.sv
// Programming write stream plus the synaptic-memory write handshake.
interface snncore_prog_rx_if #(
  parameter int unsigned NUM_LAYERS = 2,
  parameter int unsigned SYN_ADDR_W = 24
);
  logic                  mem_write;
  logic                  cfg_write;
  logic [31:0]           wr_addr;
  logic [31:0]           wr_data;
  logic [NUM_LAYERS-1:0] syn_we;
  logic [SYN_ADDR_W-1:0] syn_addr;
  logic [31:0]           syn_data;
  logic                  syn_ready;

  // Host side: issues writes and plays the synaptic memory.
  modport master (
    output mem_write, cfg_write, wr_addr, wr_data, syn_ready,
    input  syn_we, syn_addr, syn_data
  );

  modport slave (
    input  mem_write, cfg_write, wr_addr, wr_data, syn_ready,
    output syn_we, syn_addr, syn_data
  );
endinterface

// File: rtl/snncore_prog_rx_fifo.sv
// Show-ahead synchronous FIFO; push into a full FIFO is taken only alongside a pop.
module prog_fifo #(
  parameter int unsigned WIDTH = 72,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/snncore_prog_rx.sv
// snncore programming-port responder: config registers, synaptic write buffer, prog_done.
// Define SNN_PROG_STATS_EN to implement the syn_wr_cnt / drop_cnt statistics counters.
module snncore_prog_rx
  import snn_prog_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = 2,
  parameter int unsigned PRECISION  = 16,
  parameter int unsigned SYN_ADDR_W = 24,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 memclk,
  input  logic                 rst,
  snncore_prog_rx_if.slave     bus,
  output logic [PRECISION-1:0] vth,
  output logic [PRECISION-1:0] decay_rate,
  output logic [PRECISION-1:0] grow_rate,
  output logic [PRECISION-1:0] vrest,
  output logic [1:0]           reset_mechanism,
  output logic [7:0]           refractory_period,
  output logic [7:0]           layer_to_monitor,
  output logic [15:0]          neuron_to_monitor,
  output logic                 prog_done,
  output logic                 err_overflow,
  output logic                 err_bad_addr,
  output logic [31:0]          syn_wr_cnt,
  output logic [15:0]          drop_cnt
);
  localparam logic [7:0] LayerLimit = 8'(NUM_LAYERS);

  prog_state_t         state_q, state_d;
  logic [CFG_REGS-1:0] cfg_seen_q;
  syn_wr_t             wr_entry, head;
  logic [7:0]          layer_idx;
  logic                fifo_full, fifo_empty;
  logic                collision, cfg_ok, cfg_bad, mem_bad, mem_try;
  logic                pop, push_ok, overflow, drop;

  assign layer_idx = bus.wr_addr[LAYER_MSB:LAYER_LSB];
  assign collision = bus.mem_write & bus.cfg_write;
  assign cfg_ok    = bus.cfg_write & ~bus.mem_write & (bus.wr_addr[31:3] == '0);
  assign cfg_bad   = bus.cfg_write & ~bus.mem_write & (bus.wr_addr[31:3] != '0);
  assign mem_bad   = bus.mem_write & ~bus.cfg_write & (layer_idx >= LayerLimit);
  assign mem_try   = bus.mem_write & ~bus.cfg_write & (layer_idx < LayerLimit);
  assign pop       = ~fifo_empty & bus.syn_ready;
  assign push_ok   = mem_try & (~fifo_full | pop);
  assign overflow  = mem_try & fifo_full & ~pop;
  assign drop      = collision | cfg_bad | mem_bad | overflow;

  assign wr_entry = '{layer: layer_idx,
                      addr:  SYN_ADDR_W_MAX'(bus.wr_addr[SYN_ADDR_W-1:0]),
                      data:  bus.wr_data};

  prog_fifo #(
    .WIDTH ($bits(syn_wr_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (memclk),
    .rst   (rst),
    .push  (mem_try),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Outputs are gated by empty so stale (unreset) storage never reaches the memories.
  always_comb begin
    bus.syn_we   = '0;
    bus.syn_addr = '0;
    bus.syn_data = '0;
    if (!fifo_empty) begin
      for (int i = 0; i < int'(NUM_LAYERS); i++) begin
        if (head.layer == 8'(i)) bus.syn_we[i] = 1'b1;
      end
      bus.syn_addr = head.addr[SYN_ADDR_W-1:0];
      bus.syn_data = head.data;
    end
  end

  always_ff @(posedge memclk or posedge rst) begin
    if (rst) begin
      cfg_seen_q        <= '0;
      vth               <= '0;
      decay_rate        <= '0;
      grow_rate         <= '0;
      vrest             <= '0;
      reset_mechanism   <= '0;
      refractory_period <= '0;
      layer_to_monitor  <= '0;
      neuron_to_monitor <= '0;
    end else if (cfg_ok) begin
      cfg_seen_q[bus.wr_addr[2:0]] <= 1'b1;
      unique case (bus.wr_addr[2:0])
        3'(CFG_VTH):               vth               <= bus.wr_data[PRECISION-1:0];
        3'(CFG_DECAY_RATE):        decay_rate        <= bus.wr_data[PRECISION-1:0];
        3'(CFG_GROW_RATE):         grow_rate         <= bus.wr_data[PRECISION-1:0];
        3'(CFG_VREST):             vrest             <= bus.wr_data[PRECISION-1:0];
        3'(CFG_RESET_MECHANISM):   reset_mechanism   <= bus.wr_data[1:0];
        3'(CFG_REFRACTORY_PERIOD): refractory_period <= bus.wr_data[7:0];
        3'(CFG_LAYER_TO_MONITOR):  layer_to_monitor  <= bus.wr_data[7:0];
        3'(CFG_NEURON_TO_MONITOR): neuron_to_monitor <= bus.wr_data[15:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD:    if (&cfg_seen_q && fifo_empty && !push_ok) state_d = READY;
      READY:   if (push_ok) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge memclk or posedge rst) begin
    if (rst) begin
      state_q      <= LOAD;
      err_overflow <= 1'b0;
      err_bad_addr <= 1'b0;
    end else begin
      state_q <= state_d;
      if (overflow) err_overflow <= 1'b1;
      if (collision || cfg_bad || mem_bad) err_bad_addr <= 1'b1;
    end
  end

  assign prog_done = (state_q == READY);

`ifdef SNN_PROG_STATS_EN
  always_ff @(posedge memclk or posedge rst) begin
    if (rst) begin
      syn_wr_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      if (pop && syn_wr_cnt != '1) syn_wr_cnt <= syn_wr_cnt + 1'b1;
      if (drop && drop_cnt != '1)  drop_cnt   <= drop_cnt + 1'b1;
    end
  end
`else
  assign syn_wr_cnt = '0;
  assign drop_cnt   = '0;
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_snncore_prog_rx.sv
// Directed bench for snncore_prog_rx with a queue scoreboard of expected memory writes.
module tb_snncore_prog_rx;
  localparam int unsigned NL    = 2;
  localparam int unsigned PREC  = 16;
  localparam int unsigned SAW   = 24;
  localparam int unsigned DEPTH = 4;
`ifdef SNN_PROG_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic memclk = 1'b0;
  logic rst    = 1'b1;
  always #5 memclk = ~memclk;

  snncore_prog_rx_if #(.NUM_LAYERS(NL), .SYN_ADDR_W(SAW)) bus ();

  logic [PREC-1:0] vth, decay_rate, grow_rate, vrest;
  logic [1:0]      reset_mechanism;
  logic [7:0]      refractory_period, layer_to_monitor;
  logic [15:0]     neuron_to_monitor;
  logic            prog_done, err_overflow, err_bad_addr;
  logic [31:0]     syn_wr_cnt;
  logic [15:0]     drop_cnt;

  snncore_prog_rx #(
    .NUM_LAYERS (NL),
    .PRECISION  (PREC),
    .SYN_ADDR_W (SAW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .memclk            (memclk),
    .rst               (rst),
    .bus               (bus.slave),
    .vth               (vth),
    .decay_rate        (decay_rate),
    .grow_rate         (grow_rate),
    .vrest             (vrest),
    .reset_mechanism   (reset_mechanism),
    .refractory_period (refractory_period),
    .layer_to_monitor  (layer_to_monitor),
    .neuron_to_monitor (neuron_to_monitor),
    .prog_done         (prog_done),
    .err_overflow      (err_overflow),
    .err_bad_addr      (err_bad_addr),
    .syn_wr_cnt        (syn_wr_cnt),
    .drop_cnt          (drop_cnt)
  );

  typedef struct {
    logic [7:0]  layer;
    logic [23:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_ret    = 0;
  int   exp_wr   = 0;
  int   exp_drop = 0;
  int   ret_mark;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt();
    chk("syn_wr_cnt", syn_wr_cnt, STATS ? 64'(exp_wr) : 64'd0);
    chk("drop_cnt", drop_cnt, STATS ? 64'(exp_drop) : 64'd0);
  endtask

  // One clock: check the presented head at negedge, advance the model, then step past posedge.
  task automatic step();
    bit   pop, mw, cw;
    exp_t e;
    @(negedge memclk);
    if (q.size() > 0) begin
      chk("syn_we", bus.syn_we, 64'd1 << q[0].layer);
      chk("syn_addr", bus.syn_addr, q[0].addr);
      chk("syn_data", bus.syn_data, q[0].data);
    end else begin
      chk("syn_we_idle", bus.syn_we, 0);
    end
    if (bus.syn_we != 0 && bus.syn_ready) n_ret++;
    if (!rst) begin
      mw  = bus.mem_write;
      cw  = bus.cfg_write;
      pop = (q.size() > 0) && bus.syn_ready;
      e   = '{layer: bus.wr_addr[31:24], addr: bus.wr_addr[23:0], data: bus.wr_data};
      if (mw && cw) exp_drop++;
      else if (cw && bus.wr_addr[31:3] != 0) exp_drop++;
      else if (mw && bus.wr_addr[31:24] >= NL) exp_drop++;
      else if (mw && q.size() >= DEPTH && !pop) exp_drop++;
      if (pop) begin
        void'(q.pop_front());
        exp_wr++;
      end
      if (mw && !cw && bus.wr_addr[31:24] < NL && (q.size() < DEPTH || pop)) q.push_back(e);
    end
    @(posedge memclk);
    #1;
  endtask

  task automatic cyc(input bit mw, input bit cw, input logic [31:0] a, input logic [31:0] d);
    bus.mem_write = mw;
    bus.cfg_write = cw;
    bus.wr_addr   = a;
    bus.wr_data   = d;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    logic [31:0] cfg_vals [8];
    cfg_vals = '{32'h40, 32'd2, 32'd1, 32'd0, 32'd1, 32'd3, 32'd1, 32'd5};
    bus.mem_write = 1'b0;
    bus.cfg_write = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.syn_ready = 1'b1;

    // Reset values
    #1;
    chk("rst_syn_we", bus.syn_we, 0);
    chk("rst_prog_done", prog_done, 0);
    chk("rst_vth", vth, 0);
    chk("rst_errs", {err_overflow, err_bad_addr}, 0);
    chk("rst_wr_cnt", syn_wr_cnt, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    @(posedge memclk);
    @(posedge memclk);
    #1;
    rst = 1'b0;

    // Program all eight config registers
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 32'(i), cfg_vals[i]);
    chk("done_same_edge", prog_done, 0);
    chk("vth", vth, 16'h40);
    chk("decay", decay_rate, 2);
    chk("grow", grow_rate, 1);
    chk("vrest", vrest, 0);
    chk("reset_mech", reset_mechanism, 1);
    chk("refractory", refractory_period, 3);
    chk("layer_mon", layer_to_monitor, 1);
    chk("neuron_mon", neuron_to_monitor, 5);
    idle(1);
    chk("done_after_cfg", prog_done, 1);

    // Ten back-to-back writes to layer 1
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b0, 32'h0100_0000 | 32'(i * 3), 32'hA000_0000 + 32'(i));
      if (i == 0) chk("done_falls", prog_done, 0);
    end
    idle(2);
    chk("b2b_drained", q.size(), 0);
    chk("b2b_done", prog_done, 1);
    chk("b2b_retired", n_ret, 10);
    chk_cnt();

    // Overflow with the memory stalled
    bus.syn_ready = 1'b0;
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 32'h0000_0100 + 32'(i), 32'h5500_0000 + 32'(i));
    chk("ovf_flag", err_overflow, 1);
    chk("ovf_bad_addr", err_bad_addr, 0);
    chk("ovf_stored", q.size(), 4);
    chk_cnt();
    ret_mark = n_ret;
    bus.syn_ready = 1'b1;
    idle(6);
    chk("ovf_retired", n_ret - ret_mark, 4);
    chk("ovf_done", prog_done, 1);
    chk_cnt();

    // Bad layer, collision, bad config index, then live config update in READY
    cyc(1'b1, 1'b0, 32'h0500_0010, 32'h1111_1111);
    chk("bad_layer_flag", err_bad_addr, 1);
    chk("bad_layer_done", prog_done, 1);
    cyc(1'b1, 1'b1, 32'h0000_0003, 32'h99);
    chk("collide_vrest", vrest, 0);
    cyc(1'b0, 1'b1, 32'h0000_0008, 32'h77);
    chk("badcfg_vth", vth, 16'h40);
    chk_cnt();
    cyc(1'b0, 1'b1, 32'h0000_0000, 32'h1234_0077);
    chk("live_vth", vth, 16'h0077);
    chk("live_done", prog_done, 1);
    idle(1);

    // One write while READY
    cyc(1'b1, 1'b0, 32'h0000_0ABC, 32'hDEAD_BEEF);
    chk("ready_wr_fall", prog_done, 0);
    idle(1);
    chk("ready_wr_low", prog_done, 0);
    idle(1);
    chk("ready_wr_rise", prog_done, 1);
    chk_cnt();

    // Asynchronous reset with three entries queued
    bus.syn_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'h0100_0020 + 32'(i), 32'hC0DE_0000 + 32'(i));
    bus.mem_write = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_syn_we", bus.syn_we, 0);
    chk("arst_done", prog_done, 0);
    chk("arst_vth", vth, 0);
    chk("arst_errs", {err_overflow, err_bad_addr}, 0);
    q.delete();
    exp_wr   = 0;
    exp_drop = 0;
    chk_cnt();
    bus.syn_ready = 1'b1;
    idle(1);
    rst = 1'b0;
    ret_mark = n_ret;
    idle(4);
    chk("post_rst_retired", n_ret - ret_mark, 0);
    chk("post_rst_done", prog_done, 0);
    chk_cnt();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
